// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 execution core: default width and operand selector codes.
package td4_pkg;

    localparam int WIDTH = 4;

    // Operand selector codes, index = {sel_b, sel_a}
    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_IN   = 2'd2,
        SEL_ZERO = 2'd3
    } sel_e;

    function automatic sel_e sel_code(input logic sel_b, input logic sel_a);
        return sel_e'({sel_b, sel_a});
    endfunction

endpackage

// File: rtl/td4_pc_alu_if.sv
// Bus between the TD4 control/register top level and the execution core.
interface td4_pc_alu_if #(
    parameter int WIDTH = td4_pkg::WIDTH
);

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] in_port;
    logic             sel_a;
    logic             sel_b;
    logic [WIDTH-1:0] im;
    logic             pc_load;
    logic [WIDTH-1:0] alu_out;
    logic             alu_co;
    logic [WIDTH-1:0] pc;

    // Master is the CPU top level (decode + registers); slave is the execution core.
    modport master (
        output reg_a, reg_b, in_port, sel_a, sel_b, im, pc_load,
        input  alu_out, alu_co, pc
    );

    modport slave (
        input  reg_a, reg_b, in_port, sel_a, sel_b, im, pc_load,
        output alu_out, alu_co, pc
    );

endinterface

// File: rtl/td4_pc.sv
// TD4 program counter: loadable up-counter with asynchronous active-high reset.
module td4_pc #(
    parameter int WIDTH = td4_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Jump load wins over increment; increment wraps naturally at 2^WIDTH.
    always_comb begin
        pc_d = pc_q + WIDTH'(1);
        if (load_i) begin
            pc_d = load_val_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/td4_pc_alu.sv
// TD4 execution core: operand selector and adder (combinational) plus the program counter.
module td4_pc_alu
    import td4_pkg::*;
#(
    parameter int WIDTH = td4_pkg::WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    td4_pc_alu_if.slave     bus
);

    logic [WIDTH-1:0] sel_out;
    logic [WIDTH:0]   sum;

    always_comb begin
        sel_out = '0;
        unique case (sel_code(bus.sel_b, bus.sel_a))
            SEL_A:    sel_out = bus.reg_a;
            SEL_B:    sel_out = bus.reg_b;
            SEL_IN:   sel_out = bus.in_port;
            SEL_ZERO: sel_out = '0;
            default:  sel_out = '0;
        endcase
    end

    // One extra bit so the carry out falls out of the same add; no carry-in exists.
    assign sum         = {1'b0, sel_out} + {1'b0, bus.im};
    assign bus.alu_out = sum[WIDTH-1:0];
    assign bus.alu_co  = sum[WIDTH];

    td4_pc #(
        .WIDTH (WIDTH)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.pc_load),
        .load_val_i (sum[WIDTH-1:0]),
        .pc_o       (bus.pc)
    );

endmodule

// File: tb/tb_td4_pc_alu.sv
// Directed-vector bench for the TD4 execution core.
module tb_td4_pc_alu;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    td4_pc_alu_if #(.WIDTH(4)) bus ();

    td4_pc_alu #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] code);
        bus.sel_b = code[1];
        bus.sel_a = code[0];
    endtask

    task automatic chk_alu(input string tag, input logic [3:0] s, input logic c);
        #1;
        chk({tag, "_sum"}, 8'(bus.alu_out), 8'(s));
        chk({tag, "_co"},  8'(bus.alu_co),  8'(c));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        bus.reg_a   = '0;
        bus.reg_b   = '0;
        bus.in_port = '0;
        bus.sel_a   = 1'b0;
        bus.sel_b   = 1'b0;
        bus.im      = '0;
        bus.pc_load = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_pc", 8'(bus.pc), 8'h0);
        chk_alu("rst_alu", 4'b0000, 1'b0);

        // Increment and wrap
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            chk($sformatf("inc%0d", i), 8'(bus.pc), 8'((i + 1) % 16));
        end

        // Async reset mid-cycle from pc=0101
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_pc", 8'(bus.pc), 8'h5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", 8'(bus.pc), 8'h0);
        step();
        chk("rst_hold1", 8'(bus.pc), 8'h0);
        step();
        chk("rst_hold2", 8'(bus.pc), 8'h0);
        reset = 1'b0;

        // Selector / adder
        bus.reg_a = 4'b0011; bus.reg_b = 4'b0101; bus.in_port = 4'b1001; bus.im = 4'b0010;
        set_sel(2'd0); chk_alu("sel0", 4'b0101, 1'b0);
        set_sel(2'd1); chk_alu("sel1", 4'b0111, 1'b0);
        set_sel(2'd2); chk_alu("sel2", 4'b1011, 1'b0);
        set_sel(2'd3); chk_alu("sel3", 4'b0010, 1'b0);

        // Carry
        set_sel(2'd0);
        bus.reg_a = 4'b1111; bus.im = 4'b0001; chk_alu("cy1", 4'b0000, 1'b1);
        bus.reg_a = 4'b1000; bus.im = 4'b1000; chk_alu("cy2", 4'b0000, 1'b1);
        bus.reg_a = 4'b0111; bus.im = 4'b1000; chk_alu("cy3", 4'b1111, 1'b0);

        // Jump load from pc=0011
        step(); step(); step();
        chk("pre_jmp_pc", 8'(bus.pc), 8'h3);
        set_sel(2'd3);
        bus.im = 4'b1010;
        bus.pc_load = 1'b1;
        step();
        chk("jmp", 8'(bus.pc), 8'hA);
        bus.pc_load = 1'b0;
        step();
        chk("jmp_inc", 8'(bus.pc), 8'hB);
        bus.im = 4'b1011;
        bus.pc_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("self_loop%0d", i), 8'(bus.pc), 8'hB);
        end

        // Reset pulse while a load is pending
        bus.im = 4'b0111;
        #2;
        reset = 1'b1;
        #1;
        chk("ld_rst_pc", 8'(bus.pc), 8'h0);
        chk_alu("ld_rst_alu", 4'b0111, 1'b0);
        reset = 1'b0;
        #1;
        chk("ld_rst_rel", 8'(bus.pc), 8'h0);
        step();
        chk("ld_after_rst", 8'(bus.pc), 8'h7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
